// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: memory aluop codes, the NOP
// register address, the zero word, FSM state encoding and op-class helpers.
package mem_lsu_pkg;

   localparam logic [7:0] OP_LB  = 8'hE0;
   localparam logic [7:0] OP_LBU = 8'hE4;
   localparam logic [7:0] OP_LH  = 8'hE1;
   localparam logic [7:0] OP_LHU = 8'hE5;
   localparam logic [7:0] OP_LW  = 8'hE3;
   localparam logic [7:0] OP_SB  = 8'hE8;
   localparam logic [7:0] OP_SH  = 8'hE9;
   localparam logic [7:0] OP_SW  = 8'hEB;

   localparam logic [4:0]  NOP_REG   = 5'd0;
   localparam logic [31:0] ZERO_WORD = 32'h0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } lsu_state_e;

   function automatic logic is_store_op(input logic [7:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic is_mem_op(input logic [7:0] op);
      return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
             (op == OP_LHU) || (op == OP_LW) || is_store_op(op);
   endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane selection and load extraction for a big-endian 32-bit data bus.
// Purely combinational.
//   aluop_i      : memory operation code
//   addr_lo_i    : low two bits of the effective address
//   store_data_i : raw store operand
//   rdata_i      : bus read word
//   sel_o        : byte-lane enables (bit 3 = bits 31:24)
//   wdata_o      : lane-replicated store data
//   load_data_o  : extracted, sign/zero extended load value
//   misalign_o   : access not naturally aligned for its size
module mem_align
   import mem_lsu_pkg::*;
(
   input  logic [7:0]  aluop_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  sel_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_data_o,
   output logic        misalign_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [3:0]  half_sel;

   // Big-endian: offset 0 is the most significant byte of the word.
   always_comb begin
      byte_v = rdata_i[31:24];
      case (addr_lo_i)
         2'b00:   byte_v = rdata_i[31:24];
         2'b01:   byte_v = rdata_i[23:16];
         2'b10:   byte_v = rdata_i[15:8];
         default: byte_v = rdata_i[7:0];
      endcase
   end

   assign half_v   = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
   assign half_sel = addr_lo_i[1] ? 4'b0011 : 4'b1100;

   always_comb begin
      sel_o       = 4'b0000;
      wdata_o     = store_data_i;
      load_data_o = ZERO_WORD;
      misalign_o  = 1'b0;
      case (aluop_i)
         OP_LB: begin
            sel_o       = 4'b1000 >> addr_lo_i;
            load_data_o = {{24{byte_v[7]}}, byte_v};
         end
         OP_LBU: begin
            sel_o       = 4'b1000 >> addr_lo_i;
            load_data_o = {24'h0, byte_v};
         end
         OP_LH: begin
            sel_o       = half_sel;
            misalign_o  = addr_lo_i[0];
            load_data_o = {{16{half_v[15]}}, half_v};
         end
         OP_LHU: begin
            sel_o       = half_sel;
            misalign_o  = addr_lo_i[0];
            load_data_o = {16'h0, half_v};
         end
         OP_LW: begin
            sel_o       = 4'b1111;
            misalign_o  = |addr_lo_i;
            load_data_o = rdata_i;
         end
         OP_SB: begin
            sel_o   = 4'b1000 >> addr_lo_i;
            wdata_o = {4{store_data_i[7:0]}};
         end
         OP_SH: begin
            sel_o      = half_sel;
            misalign_o = addr_lo_i[0];
            wdata_o    = {2{store_data_i[15:0]}};
         end
         OP_SW: begin
            sel_o      = 4'b1111;
            misalign_o = |addr_lo_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// Memory stage load/store unit. Non-memory ops pass straight through to the
// write-back register; aligned memory ops run IDLE -> REQ -> DONE, stalling
// upstream until the bus acknowledges. Misaligned ops raise a one-cycle
// exception (registered, visible the cycle after the op) and issue nothing.
//   clk, rst               : clock, async active-low reset
//   in_*                   : instruction slot from the execute stage
//   dbus_*                 : data bus (word-aligned address, lane enables)
//   mem_wd/wreg/wdata      : result to the write-back pipeline register
//   stallreq               : hold upstream stages
//   exc_misalign/badaddr   : alignment exception pulse and faulting address
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int DW     = 32,
   parameter int AW_REG = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_wreg,
   input  logic [AW_REG-1:0] in_wd,
   input  logic [DW-1:0]     in_wdata,
   input  logic [7:0]        in_aluop,
   input  logic [DW-1:0]     in_addr,
   input  logic [DW-1:0]     in_store_data,
   output logic              dbus_req,
   output logic              dbus_we,
   output logic [DW-1:0]     dbus_addr,
   output logic [DW-1:0]     dbus_wdata,
   output logic [3:0]        dbus_sel,
   input  logic              dbus_ack,
   input  logic [DW-1:0]     dbus_rdata,
   output logic [AW_REG-1:0] mem_wd,
   output logic              mem_wreg,
   output logic [DW-1:0]     mem_wdata,
   output logic              stallreq,
   output logic              exc_misalign,
   output logic [DW-1:0]     exc_badaddr
);

   lsu_state_e state_q;
   logic       req_q;
   logic       exc_q;
   logic [DW-1:0] rdata_q;
   logic [DW-1:0] badaddr_q;

   logic [3:0]    sel;
   logic [DW-1:0] st_wdata;
   logic [DW-1:0] ld_data;
   logic          misalign;
   logic          mem_op;
   logic          st_op;
   logic          accept;
   logic          bad;

   mem_align u_align (
      .aluop_i      (in_aluop),
      .addr_lo_i    (in_addr[1:0]),
      .store_data_i (in_store_data),
      .rdata_i      (dbus_rdata),
      .sel_o        (sel),
      .wdata_o      (st_wdata),
      .load_data_o  (ld_data),
      .misalign_o   (misalign)
   );

   assign mem_op = is_mem_op(in_aluop);
   assign st_op  = is_store_op(in_aluop);
   assign accept = (state_q == S_IDLE) && in_valid && mem_op && !misalign;
   assign bad    = (state_q == S_IDLE) && in_valid && mem_op && misalign;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         req_q     <= 1'b0;
         rdata_q   <= ZERO_WORD;
         exc_q     <= 1'b0;
         badaddr_q <= ZERO_WORD;
      end else begin
         exc_q <= bad;
         if (bad) badaddr_q <= in_addr;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  state_q <= S_REQ;
                  req_q   <= 1'b1;
               end
            end
            S_REQ: begin
               if (dbus_ack) begin
                  // Stores write back zero; only loads carry bus data forward.
                  rdata_q <= st_op ? ZERO_WORD : ld_data;
                  state_q <= S_DONE;
                  req_q   <= 1'b0;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   // Address and store data come straight from the slot, which upstream holds
   // stable while stalled; we/sel are qualified so they only show during REQ.
   assign dbus_req     = req_q;
   assign dbus_we      = req_q & st_op;
   assign dbus_sel     = req_q ? sel : 4'b0000;
   assign dbus_addr    = {in_addr[DW-1:2], 2'b00};
   assign dbus_wdata   = st_wdata;
   assign exc_misalign = exc_q;
   assign exc_badaddr  = badaddr_q;

   always_comb begin
      mem_wd    = AW_REG'(NOP_REG);
      mem_wreg  = 1'b0;
      mem_wdata = ZERO_WORD;
      stallreq  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               stallreq = 1'b1;
            end else if (in_valid && !mem_op) begin
               mem_wd    = in_wd;
               mem_wreg  = in_wreg;
               mem_wdata = in_wdata;
            end
         end
         S_REQ:  stallreq = 1'b1;
         S_DONE: begin
            mem_wd    = in_wd;
            mem_wreg  = in_wreg;
            mem_wdata = rdata_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: pass-through, loads of every width, stores
// with and without wait states, misalignment, invalid slot, async reset.
module tb_mem_lsu;
   import mem_lsu_pkg::*;

   logic        clk, rst;
   logic        in_valid, in_wreg;
   logic [4:0]  in_wd;
   logic [31:0] in_wdata;
   logic [7:0]  in_aluop;
   logic [31:0] in_addr, in_store_data;
   logic        dbus_req, dbus_we;
   logic [31:0] dbus_addr, dbus_wdata;
   logic [3:0]  dbus_sel;
   logic        dbus_ack;
   logic [31:0] dbus_rdata;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic        stallreq, exc_misalign;
   logic [31:0] exc_badaddr;

   int checks = 0;
   int failures = 0;

   mem_lsu dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_wreg(in_wreg), .in_wd(in_wd), .in_wdata(in_wdata),
      .in_aluop(in_aluop), .in_addr(in_addr), .in_store_data(in_store_data),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
      .dbus_wdata(dbus_wdata), .dbus_sel(dbus_sel), .dbus_ack(dbus_ack),
      .dbus_rdata(dbus_rdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
      .mem_wdata(mem_wdata), .stallreq(stallreq), .exc_misalign(exc_misalign),
      .exc_badaddr(exc_badaddr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] op, input logic [31:0] addr,
                        input logic [4:0] wd, input logic wreg);
      in_valid = 1'b1;
      in_aluop = op;
      in_addr  = addr;
      in_wd    = wd;
      in_wreg  = wreg;
   endtask

   // Aligned load, ack on the first REQ cycle.
   task automatic do_load(input string tag, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [3:0] sel,
                          input logic [31:0] exp);
      tick();
      drive(op, addr, 5'd7, 1'b1);
      dbus_rdata = rdata;
      dbus_ack   = 1'b0;
      #2;
      chk({tag, "_acc_stall"}, stallreq, 1);
      chk({tag, "_acc_bubble"}, {mem_wreg, mem_wdata[30:0]}, 0);
      chk({tag, "_acc_req"}, dbus_req, 0);
      tick();
      dbus_ack = 1'b1;
      #2;
      chk({tag, "_req"}, dbus_req, 1);
      chk({tag, "_we"}, dbus_we, 0);
      chk({tag, "_sel"}, dbus_sel, sel);
      chk({tag, "_addr"}, dbus_addr, {addr[31:2], 2'b00});
      chk({tag, "_req_stall"}, stallreq, 1);
      tick();
      dbus_ack = 1'b0;
      #2;
      chk({tag, "_done_stall"}, stallreq, 0);
      chk({tag, "_done_req"}, dbus_req, 0);
      chk({tag, "_done_wd"}, mem_wd, 7);
      chk({tag, "_done_wreg"}, mem_wreg, 1);
      chk({tag, "_done_data"}, mem_wdata, exp);
      in_valid = 1'b0;
   endtask

   // Aligned store with 'waits' REQ cycles before the ack.
   task automatic do_store(input string tag, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] sel,
                           input logic [31:0] wdata, input int waits);
      int reqs;
      tick();
      drive(op, addr, 5'd0, 1'b0);
      in_store_data = data;
      dbus_ack = 1'b0;
      #2;
      chk({tag, "_acc_stall"}, stallreq, 1);
      reqs = 0;
      for (int i = 0; i <= waits; i++) begin
         tick();
         dbus_ack = (i == waits);
         #2;
         chk({tag, "_req"}, dbus_req, 1);
         chk({tag, "_we"}, dbus_we, 1);
         chk({tag, "_sel"}, dbus_sel, sel);
         chk({tag, "_wdata"}, dbus_wdata, wdata);
         chk({tag, "_addr"}, dbus_addr, {addr[31:2], 2'b00});
         chk({tag, "_stall"}, stallreq, 1);
         if (dbus_req) reqs++;
      end
      tick();
      dbus_ack = 1'b0;
      #2;
      chk({tag, "_req_cycles"}, reqs, waits + 1);
      chk({tag, "_done_stall"}, stallreq, 0);
      chk({tag, "_done_req"}, dbus_req, 0);
      chk({tag, "_done_data"}, mem_wdata, 0);
      in_valid = 1'b0;
   endtask

   task automatic do_misalign(input string tag, input logic [7:0] op, input logic [31:0] addr);
      tick();
      drive(op, addr, 5'd9, 1'b1);
      #2;
      chk({tag, "_stall"}, stallreq, 0);
      chk({tag, "_bubble"}, {mem_wd, mem_wreg, mem_wdata[25:0]}, 0);
      chk({tag, "_exc_pre"}, exc_misalign, 0);
      tick();
      in_valid = 1'b0;
      #2;
      chk({tag, "_exc"}, exc_misalign, 1);
      chk({tag, "_badaddr"}, exc_badaddr, addr);
      chk({tag, "_noreq"}, dbus_req, 0);
      tick();
      #2;
      chk({tag, "_exc_end"}, exc_misalign, 0);
      chk({tag, "_noreq2"}, dbus_req, 0);
   endtask

   initial begin
      rst = 1'b0;
      in_valid = 1'b0; in_wreg = 1'b0; in_wd = 5'd0; in_wdata = 32'h0;
      in_aluop = 8'h00; in_addr = 32'h0; in_store_data = 32'h0;
      dbus_ack = 1'b0; dbus_rdata = 32'h0;
      #3;
      chk("rst_req", dbus_req, 0);
      chk("rst_stall", stallreq, 0);
      chk("rst_exc", exc_misalign, 0);
      chk("rst_badaddr", exc_badaddr, 0);
      chk("rst_wreg", mem_wreg, 0);
      #9 rst = 1'b1;

      // ALU pass-through
      tick();
      drive(8'h21, 32'h0, 5'd3, 1'b1);
      in_wdata = 32'h1234;
      #2;
      chk("alu_wd", mem_wd, 3);
      chk("alu_wreg", mem_wreg, 1);
      chk("alu_wdata", mem_wdata, 32'h1234);
      chk("alu_stall", stallreq, 0);
      chk("alu_req", dbus_req, 0);

      // stray ack in IDLE
      dbus_ack = 1'b1;
      in_wdata = 32'h5678;
      tick();
      #2;
      chk("stray_wdata", mem_wdata, 32'h5678);
      chk("stray_stall", stallreq, 0);
      chk("stray_req", dbus_req, 0);
      tick();
      dbus_ack = 1'b0;
      #2;
      chk("stray_req2", dbus_req, 0);
      chk("stray_wdata2", mem_wdata, 32'h5678);
      in_valid = 1'b0;

      do_load("lb",  OP_LB,  32'h101, 32'h0080_0000, 4'b0100, 32'hFFFF_FF80);
      do_load("lbu", OP_LBU, 32'h103, 32'h0000_00A5, 4'b0001, 32'h0000_00A5);
      do_load("lh",  OP_LH,  32'h100, 32'h8001_0000, 4'b1100, 32'hFFFF_8001);
      do_load("lhu", OP_LHU, 32'h102, 32'h0000_9ABC, 4'b0011, 32'h0000_9ABC);
      do_load("lw",  OP_LW,  32'h104, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

      do_store("sh", OP_SH, 32'h202, 32'h1234_BEEF, 4'b0011, 32'hBEEF_BEEF, 4);
      do_store("sb", OP_SB, 32'h101, 32'hAABB_CC7F, 4'b0100, 32'h7F7F_7F7F, 0);
      do_store("sw", OP_SW, 32'h208, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1);

      do_misalign("mis_lw", OP_LW, 32'h6);
      do_misalign("mis_sh", OP_SH, 32'h201);

      // invalid slot carrying an aligned load
      tick();
      drive(OP_LW, 32'h100, 5'd4, 1'b1);
      in_valid = 1'b0;
      #2;
      chk("inv_stall", stallreq, 0);
      chk("inv_wreg", mem_wreg, 0);
      tick();
      #2;
      chk("inv_req", dbus_req, 0);

      // async reset in the middle of REQ
      tick();
      drive(OP_LW, 32'h10, 5'd5, 1'b1);
      tick();
      #2;
      chk("arst_req_pre", dbus_req, 1);
      #1 rst = 1'b0;
      #1;
      chk("arst_req", dbus_req, 0);
      chk("arst_badaddr", exc_badaddr, 0);
      in_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      dbus_ack = 1'b1;
      tick();
      #2;
      chk("late_ack_req", dbus_req, 0);
      chk("late_ack_stall", stallreq, 0);
      chk("late_ack_wreg", mem_wreg, 0);
      dbus_ack = 1'b0;
      tick();
      #2;
      chk("late_ack_req2", dbus_req, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
